// File: rtl/map_arbiter_pkg.sv
// Shared constants and requester IDs for the map ROM arbiter slice.
package map_arbiter_pkg;

    localparam int MAP_ADDR_W    = 4;
    localparam int MAP_CELL_BITS = 2;

    typedef enum logic {
        REQ_TRACER  = 1'b0,
        REQ_OVERLAY = 1'b1
    } req_id_t;

endpackage

// File: rtl/map_arbiter_if.sv
// Request/response handshake bundle between the two map requesters and the arbiter.
interface map_arbiter_if
    import map_arbiter_pkg::*;
#(
    parameter int ADDR_W = MAP_ADDR_W,
    parameter int BITS   = MAP_CELL_BITS
);

    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_row;
    logic [ADDR_W-1:0] req0_col;
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [BITS-1:0]   rsp0_val;

    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_row;
    logic [ADDR_W-1:0] req1_col;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [BITS-1:0]   rsp1_val;

    modport master (
        output req0_valid, req0_row, req0_col, rsp0_ready,
        output req1_valid, req1_row, req1_col, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_val,
        input  req1_ready, rsp1_valid, rsp1_val
    );

    modport slave (
        input  req0_valid, req0_row, req0_col, rsp0_ready,
        input  req1_valid, req1_row, req1_col, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_val,
        output req1_ready, rsp1_valid, rsp1_val
    );

endinterface

// File: rtl/map_rsp_slot.sv
// One-entry response holding register: filled by the ROM pipe, drained by the requester.
module map_rsp_slot
    import map_arbiter_pkg::*;
#(
    parameter int BITS = MAP_CELL_BITS
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic [BITS-1:0] load_val,
    input  logic            rsp_ready,
    output logic            rsp_valid,
    output logic [BITS-1:0] rsp_val
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_val   <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_val   <= load_val;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/map_arbiter.sv
// Round-robin arbiter sharing the map ROM between the ray tracer and the overlay renderer,
// with a registered address stage and one response slot per requester.
module map_arbiter
    import map_arbiter_pkg::*;
#(
    parameter int BITS   = MAP_CELL_BITS,
    parameter int ADDR_W = MAP_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    map_arbiter_if.slave      bus,
    output logic [ADDR_W-1:0] rom_row,
    output logic [ADDR_W-1:0] rom_col,
    input  logic [BITS-1:0]   rom_val
);

    logic            pipe_vld;
    req_id_t         pipe_id;
    req_id_t         rr_last;
    logic            elig0, elig1;
    logic            grant0, grant1;
    logic            slot0_vld, slot1_vld;
    logic [BITS-1:0] slot0_val, slot1_val;

    // A requester is blocked while its slot is full or its lookup is still in the pipe.
    always_comb begin
        elig0  = bus.req0_valid && !slot0_vld && !(pipe_vld && pipe_id == REQ_TRACER);
        elig1  = bus.req1_valid && !slot1_vld && !(pipe_vld && pipe_id == REQ_OVERLAY);
        grant0 = elig0 && (!elig1 || rr_last == REQ_OVERLAY);
        grant1 = elig1 && (!elig0 || rr_last == REQ_TRACER);
    end

    // Ready is forced low while reset is asserted so nothing looks accepted during reset.
    assign bus.req0_ready = grant0 & reset_n;
    assign bus.req1_ready = grant1 & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld <= 1'b0;
            pipe_id  <= REQ_TRACER;
            rr_last  <= REQ_OVERLAY;
            rom_row  <= '0;
            rom_col  <= '0;
        end else begin
            pipe_vld <= grant0 | grant1;
            if (grant0) begin
                rom_row <= bus.req0_row;
                rom_col <= bus.req0_col;
                pipe_id <= REQ_TRACER;
                rr_last <= REQ_TRACER;
            end else if (grant1) begin
                rom_row <= bus.req1_row;
                rom_col <= bus.req1_col;
                pipe_id <= REQ_OVERLAY;
                rr_last <= REQ_OVERLAY;
            end
        end
    end

    map_rsp_slot #(.BITS(BITS)) u_slot0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (pipe_vld && pipe_id == REQ_TRACER),
        .load_val  (rom_val),
        .rsp_ready (bus.rsp0_ready),
        .rsp_valid (slot0_vld),
        .rsp_val   (slot0_val)
    );

    map_rsp_slot #(.BITS(BITS)) u_slot1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (pipe_vld && pipe_id == REQ_OVERLAY),
        .load_val  (rom_val),
        .rsp_ready (bus.rsp1_ready),
        .rsp_valid (slot1_vld),
        .rsp_val   (slot1_val)
    );

    assign bus.rsp0_valid = slot0_vld;
    assign bus.rsp0_val   = slot0_val;
    assign bus.rsp1_valid = slot1_vld;
    assign bus.rsp1_val   = slot1_val;

endmodule
